// File: rtl/rsmem_issue_sched.sv
// rsmem_issue_sched: in-order memory RS issue scheduler with LDQ/STQ credits and serialize FSM
module rsmem_issue_sched #(
    parameter int NUM_REQ   = 2,
    parameter int LDQ_DEPTH = 8,
    parameter int STQ_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Stall,
    input  logic                             Flush,
    input  logic [NUM_REQ-1:0]               RSMEM_IssueReq_Valid,
    input  logic [2*NUM_REQ-1:0]             Req_Class,
    input  logic [$clog2(NUM_REQ+1)-1:0]     Ldq_Release,
    input  logic [$clog2(NUM_REQ+1)-1:0]     Stq_Release,
    input  logic                             Serial_Done,
    output logic [NUM_REQ-1:0]               RSMEM_Issued_Valid,
    output logic [$clog2(LDQ_DEPTH):0]       Ldq_Credits,
    output logic [$clog2(STQ_DEPTH):0]       Stq_Credits,
    output logic                             Sched_Busy,
    output logic                             Credit_Err
);
    localparam int LW = $clog2(LDQ_DEPTH) + 1;
    localparam int SW = $clog2(STQ_DEPTH) + 1;
    localparam logic [LW-1:0] LD_FULL = LW'(LDQ_DEPTH);
    localparam logic [SW-1:0] ST_FULL = SW'(STQ_DEPTH);
    localparam logic [LW:0]   LD_MAX  = (LW+1)'(LDQ_DEPTH);
    localparam logic [SW:0]   ST_MAX  = (SW+1)'(STQ_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_WAIT} state_t;

    state_t          r_state, w_next;
    logic [LW-1:0]   r_ldq, w_nld;
    logic [SW-1:0]   r_stq;
    logic            r_err, w_nst, w_chain, w_ser0, w_full, w_live;
    logic [NUM_REQ-1:0] w_grant;
    logic [LW:0]     w_ld_sum;
    logic [SW:0]     w_st_sum;

    assign w_ser0   = RSMEM_IssueReq_Valid[0] && (Req_Class[1:0] == 2'b10);
    assign w_full   = (r_ldq == LD_FULL) && (r_stq == ST_FULL);
    assign w_live   = !rst && !Flush && !Stall;
    assign w_ld_sum = (LW+1)'(r_ldq) - (LW+1)'(w_nld) + (LW+1)'(Ldq_Release);
    assign w_st_sum = (SW+1)'(r_stq) - (SW+1)'(w_nst) + (SW+1)'(Stq_Release);

    assign RSMEM_Issued_Valid = w_grant;
    assign Ldq_Credits        = r_ldq;
    assign Stq_Credits        = r_stq;
    assign Sched_Busy         = (r_state != S_IDLE);
    assign Credit_Err         = r_err;

    // Grant the longest in-order prefix the credits and port limits allow, and pick the next FSM state
    always_comb begin
        w_grant = '0;
        w_nld   = '0;
        w_nst   = 1'b0;
        w_chain = 1'b1;
        w_next  = r_state;
        if (w_live && r_state == S_IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_chain && RSMEM_IssueReq_Valid[k]) begin
                    case (Req_Class[2*k +: 2])
                        2'b00: begin
                            if (r_ldq > w_nld) begin
                                w_grant[k] = 1'b1;
                                w_nld      = w_nld + LW'(1);
                            end else begin
                                w_chain = 1'b0;
                            end
                        end
                        2'b01: begin
                            if (r_stq != '0 && !w_nst) begin
                                w_grant[k] = 1'b1;
                                w_nst      = 1'b1;
                            end else begin
                                w_chain = 1'b0;
                            end
                        end
                        2'b10: begin
                            w_grant[k] = (k == 0) && w_full;
                            w_chain    = 1'b0;
                        end
                        default: w_chain = 1'b0;
                    endcase
                end else begin
                    w_chain = 1'b0;
                end
            end
        end else if (w_live && r_state == S_DRAIN && w_full && w_ser0) begin
            w_grant[0] = 1'b1;
        end
        case (r_state)
            S_IDLE:  w_next = (w_ser0 && w_grant[0]) ? S_WAIT : (w_ser0 && !Stall) ? S_DRAIN : S_IDLE;
            S_DRAIN: w_next = w_grant[0] ? S_WAIT : (!w_ser0 && !Stall) ? S_IDLE : S_DRAIN;
            S_WAIT:  w_next = Serial_Done ? S_IDLE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    // State, credit counters with clamping, and the sticky over-release flag
    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            r_state <= S_IDLE;
            r_ldq   <= LD_FULL;
            r_stq   <= ST_FULL;
        end else begin
            r_state <= w_next;
            r_ldq   <= (w_ld_sum > LD_MAX) ? LD_FULL : w_ld_sum[LW-1:0];
            r_stq   <= (w_st_sum > ST_MAX) ? ST_FULL : w_st_sum[SW-1:0];
        end
        if (rst)
            r_err <= 1'b0;
        else if (!Flush && (w_ld_sum > LD_MAX || w_st_sum > ST_MAX))
            r_err <= 1'b1;
    end
endmodule

// File: tb/tb_rsmem_issue_sched.sv
// tb_rsmem_issue_sched: directed tests for the memory issue scheduler
module tb_rsmem_issue_sched;
    logic       clk = 1'b0;
    logic       rst, stall, flush, sdone;
    logic [1:0] vld;
    logic [3:0] cls;
    logic [1:0] lrel, srel;
    logic [1:0] grant;
    logic [3:0] ldq, stq;
    logic       busy, err;
    int         errors = 0;
    int         checks = 0;

    rsmem_issue_sched dut (
        .clk(clk), .rst(rst), .Stall(stall), .Flush(flush),
        .RSMEM_IssueReq_Valid(vld), .Req_Class(cls),
        .Ldq_Release(lrel), .Stq_Release(srel), .Serial_Done(sdone),
        .RSMEM_Issued_Valid(grant), .Ldq_Credits(ldq), .Stq_Credits(stq),
        .Sched_Busy(busy), .Credit_Err(err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        stall = 0; flush = 0; sdone = 0; vld = 2'b00; cls = 4'b0000; lrel = 0; srel = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1; vld = 2'b11; cls = 4'b0000;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        step();
        rst = 0; vld = 2'b00;
        @(negedge clk);
        checks++; if (ldq !== 4'd8) begin errors++; $display("FAIL rst_ldq: got %0d want 8", ldq); end
        checks++; if (stq !== 4'd8) begin errors++; $display("FAIL rst_stq: got %0d want 8", stq); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_idle_grant: got %b want 00", grant); end
    endtask

    task automatic test_two_loads;
        do_reset();
        vld = 2'b11; cls = 4'b0000;
        @(negedge clk);
        checks++; if (grant !== 2'b11) begin errors++; $display("FAIL two_loads_grant: got %b want 11", grant); end
        step();
        vld = 2'b00;
        @(negedge clk);
        checks++; if (ldq !== 4'd6) begin errors++; $display("FAIL two_loads_ldq: got %0d want 6", ldq); end
        checks++; if (stq !== 4'd8) begin errors++; $display("FAIL two_loads_stq: got %0d want 8", stq); end
    endtask

    task automatic test_load_store;
        do_reset();
        vld = 2'b11; cls = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 2'b11) begin errors++; $display("FAIL ld_st_grant: got %b want 11", grant); end
        step();
        cls = 4'b0101;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL st_st_grant: got %b want 01", grant); end
        checks++; if (stq !== 4'd7) begin errors++; $display("FAIL st_st_stq_before: got %0d want 7", stq); end
        step();
        vld = 2'b00;
        @(negedge clk);
        checks++; if (stq !== 4'd6) begin errors++; $display("FAIL st_st_stq_after: got %0d want 6", stq); end
        checks++; if (ldq !== 4'd7) begin errors++; $display("FAIL ld_st_ldq: got %0d want 7", ldq); end
    endtask

    task automatic test_ldq_exhaust;
        do_reset();
        vld = 2'b11; cls = 4'b0000;
        for (int i = 0; i < 3; i++) step();
        vld = 2'b01;
        step();
        vld = 2'b11;
        @(negedge clk);
        checks++; if (ldq !== 4'd1) begin errors++; $display("FAIL exh_ldq1: got %0d want 1", ldq); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL exh_grant_one: got %b want 01", grant); end
        step();
        lrel = 2'd2;
        @(negedge clk);
        checks++; if (ldq !== 4'd0) begin errors++; $display("FAIL exh_ldq0: got %0d want 0", ldq); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL exh_grant_none: got %b want 00", grant); end
        step();
        lrel = 2'd0;
        @(negedge clk);
        checks++; if (grant !== 2'b11) begin errors++; $display("FAIL exh_grant_after_rel: got %b want 11", grant); end
        step();
        vld = 2'b00;
        @(negedge clk);
        checks++; if (ldq !== 4'd0) begin errors++; $display("FAIL exh_ldq_end: got %0d want 0", ldq); end
    endtask

    task automatic test_serial_drain;
        do_reset();
        vld = 2'b11; cls = 4'b0000;
        step();
        vld = 2'b01;
        step();
        cls = 4'b0010;
        @(negedge clk);
        checks++; if (ldq !== 4'd5) begin errors++; $display("FAIL ser_ldq5: got %0d want 5", ldq); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ser_idle_grant: got %b want 00", grant); end
        step();
        lrel = 2'd2;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ser_drain_busy: got %b want 1", busy); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ser_drain_grant0: got %b want 00", grant); end
        step();
        lrel = 2'd1;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ser_drain_grant1: got %b want 00", grant); end
        step();
        lrel = 2'd0;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ser_grant: got %b want 01", grant); end
        step();
        cls = 4'b0000; stall = 1; sdone = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ser_wait_busy: got %b want 1", busy); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ser_wait_grant: got %b want 00", grant); end
        checks++; if (ldq !== 4'd8) begin errors++; $display("FAIL ser_no_credit: got %0d want 8", ldq); end
        step();
        stall = 0; sdone = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ser_done_busy: got %b want 0", busy); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ser_done_grant: got %b want 01", grant); end
    endtask

    task automatic test_serial_port1;
        do_reset();
        vld = 2'b11; cls = 4'b1000;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL p1_grant: got %b want 01", grant); end
        step();
        vld = 2'b01; cls = 4'b0010;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL p1_next_grant: got %b want 00", grant); end
        step();
        lrel = 2'd1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL p1_drain_busy: got %b want 1", busy); end
        step();
        lrel = 2'd0;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL p1_ser_grant: got %b want 01", grant); end
        step();
        vld = 2'b00; sdone = 1;
        step();
        sdone = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL p1_idle: got %b want 0", busy); end
    endtask

    task automatic test_flush_overrelease;
        do_reset();
        vld = 2'b01; cls = 4'b0000;
        step();
        cls = 4'b0010;
        step();
        flush = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_drain_busy: got %b want 1", busy); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fl_grant: got %b want 00", grant); end
        step();
        flush = 0; vld = 2'b00;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy: got %b want 0", busy); end
        checks++; if (ldq !== 4'd8) begin errors++; $display("FAIL fl_ldq: got %0d want 8", ldq); end
        checks++; if (stq !== 4'd8) begin errors++; $display("FAIL fl_stq: got %0d want 8", stq); end
        flush = 1; vld = 2'b11; cls = 4'b0000;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL fl_idle_grant: got %b want 00", grant); end
        step();
        flush = 0; vld = 2'b00; srel = 2'd1;
        step();
        srel = 2'd0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b want 1", err); end
        checks++; if (stq !== 4'd8) begin errors++; $display("FAIL ovr_stq: got %0d want 8", stq); end
        flush = 1;
        step();
        flush = 0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovr_err_flush: got %b want 1", err); end
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovr_err_rst: got %b want 0", err); end
    endtask

    task automatic test_stall_reserved;
        do_reset();
        vld = 2'b11; cls = 4'b0000;
        step();
        stall = 1; lrel = 2'd1;
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL stall_grant: got %b want 00", grant); end
        step();
        stall = 0; lrel = 2'd0; cls = 4'b0011;
        @(negedge clk);
        checks++; if (ldq !== 4'd7) begin errors++; $display("FAIL stall_release: got %0d want 7", ldq); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rsv_grant: got %b want 00", grant); end
        cls = 4'b1100;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rsv_p1_grant: got %b want 01", grant); end
        step();
        vld = 2'b00;
    endtask

    initial begin
        test_reset();
        test_two_loads();
        test_load_store();
        test_ldq_exhaust();
        test_serial_drain();
        test_serial_port1();
        test_flush_overrelease();
        test_stall_reserved();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
